multi_channel_clock_divider: RTL

Parametrised successor to the single-channel adjustable divider. It generates CHANNELS independent divided clocks from one input clock. Each channel has a programmable period and a programmable high time (duty cycle). Settings are double-buffered, so a change takes effect only at a period boundary and the output never glitches. A common Sync input phase-aligns all channels. The block sits between the system clock and slow peripherals (PWM, serial bit clocks, LED scanners).

---
 rtl/multi_channel_clock_divider.sv | 104 ++++++++++
 1 files changed

// File: rtl/multi_channel_clock_divider.sv
// CHANNELS independent clock dividers with programmable period and high time.
// Settings are double-buffered and applied only at period boundaries; a shared sync restarts all channels.
module multi_channel_clock_divider #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8
) (
   input  logic                      i_clk_input,
   input  logic                      i_reset,
   input  logic [CHANNELS-1:0]       i_enable,
   input  logic                      i_sync,
   input  logic [CHANNELS-1:0]       i_load,
   input  logic [CHANNELS*WIDTH-1:0] i_divider_factor,
   input  logic [CHANNELS*WIDTH-1:0] i_high_count,
   output logic [CHANNELS-1:0]       o_clk_output,
   output logic [CHANNELS-1:0]       o_tick,
   output logic [CHANNELS-1:0]       o_pending
);

   logic [WIDTH-1:0]    r_cnt   [CHANNELS];
   logic [WIDTH-1:0]    r_act_n [CHANNELS];
   logic [WIDTH-1:0]    r_act_h [CHANNELS];
   logic [WIDTH-1:0]    r_sh_n  [CHANNELS];
   logic [WIDTH-1:0]    r_sh_h  [CHANNELS];
   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] r_clk_out;
   logic [CHANNELS-1:0] r_tick;

   logic [WIDTH-1:0]    w_new_n     [CHANNELS];
   logic [WIDTH-1:0]    w_new_h     [CHANNELS];
   logic [WIDTH-1:0]    w_cnt_nxt   [CHANNELS];
   logic [WIDTH-1:0]    w_act_n_nxt [CHANNELS];
   logic [WIDTH-1:0]    w_act_h_nxt [CHANNELS];
   logic [WIDTH-1:0]    w_sh_n_nxt  [CHANNELS];
   logic [WIDTH-1:0]    w_sh_h_nxt  [CHANNELS];
   logic [CHANNELS-1:0] w_bnd;
   logic [CHANNELS-1:0] w_pend_nxt;
   logic [CHANNELS-1:0] w_clk_nxt;
   logic [CHANNELS-1:0] w_tick_nxt;

   // Per-channel next state; a load on a boundary edge bypasses the shadow straight into the active pair.
   always_comb begin
      w_bnd      = '0;
      w_pend_nxt = r_pend;
      w_clk_nxt  = r_clk_out;
      w_tick_nxt = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         w_new_n[c]     = i_divider_factor[c*WIDTH +: WIDTH];
         w_new_h[c]     = i_high_count[c*WIDTH +: WIDTH];
         w_cnt_nxt[c]   = r_cnt[c];
         w_act_n_nxt[c] = r_act_n[c];
         w_act_h_nxt[c] = r_act_h[c];
         w_sh_n_nxt[c]  = i_load[c] ? w_new_n[c] : r_sh_n[c];
         w_sh_h_nxt[c]  = i_load[c] ? w_new_h[c] : r_sh_h[c];
         w_pend_nxt[c]  = r_pend[c] | i_load[c];
         w_bnd[c]       = i_enable[c] & (i_sync | (r_cnt[c] == r_act_n[c]));

         if (i_enable[c]) begin
            if (w_bnd[c]) begin
               w_cnt_nxt[c] = '0;
               if (r_pend[c] | i_load[c]) begin
                  w_act_n_nxt[c] = i_load[c] ? w_new_n[c] : r_sh_n[c];
                  w_act_h_nxt[c] = i_load[c] ? w_new_h[c] : r_sh_h[c];
               end
               w_pend_nxt[c] = 1'b0;
            end else begin
               w_cnt_nxt[c] = r_cnt[c] + WIDTH'(1);
            end
            w_clk_nxt[c]  = (w_cnt_nxt[c] < w_act_h_nxt[c]);
            w_tick_nxt[c] = (w_cnt_nxt[c] == '0);
         end
      end
   end

   always_ff @(posedge i_clk_input or posedge i_reset) begin
      if (i_reset) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            r_cnt[c]   <= '0;
            r_act_n[c] <= '0;
            r_act_h[c] <= '0;
            r_sh_n[c]  <= '0;
            r_sh_h[c]  <= '0;
         end
         r_pend    <= '0;
         r_clk_out <= '0;
         r_tick    <= '0;
      end else begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            r_cnt[c]   <= w_cnt_nxt[c];
            r_act_n[c] <= w_act_n_nxt[c];
            r_act_h[c] <= w_act_h_nxt[c];
            r_sh_n[c]  <= w_sh_n_nxt[c];
            r_sh_h[c]  <= w_sh_h_nxt[c];
         end
         r_pend    <= w_pend_nxt;
         r_clk_out <= w_clk_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   assign o_clk_output = r_clk_out;
   assign o_tick       = r_tick;
   assign o_pending    = r_pend;

endmodule
